// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: FSM states, owner codes and streak sizing.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_owner_e;

  // Bits needed to hold a streak count from 0 up to max_streak inclusive.
  function automatic int unsigned streak_width(input int unsigned max_streak);
    return (max_streak < 2) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for one IDLE cycle: D first, unless I has waited through a full D streak.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned STREAK_W   = streak_width(MAX_STREAK)
) (
  input  logic                i_valid,
  input  logic                d_valid,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_i_c,
  output logic                grant_d_c,
  output logic [STREAK_W-1:0] streak_nxt_c
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  logic sat_c;

  assign sat_c = (streak == STREAK_MAX);

  always_comb begin
    grant_i_c    = 1'b0;
    grant_d_c    = 1'b0;
    streak_nxt_c = streak;

    if (d_valid && !(sat_c && i_valid)) begin
      grant_d_c = 1'b1;
    end else if (i_valid) begin
      grant_i_c = 1'b1;
    end

    // Only D grants that made I wait count toward the streak.
    if (grant_d_c && i_valid) begin
      streak_nxt_c = sat_c ? streak : streak + STREAK_W'(1);
    end else if (grant_d_c || grant_i_c) begin
      streak_nxt_c = '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D), one transaction at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_resp_valid,
  output logic [DATA_W-1:0]   i_resp_rdata,

  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned STREAK_W = streak_width(MAX_STREAK);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                run_q;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                i_resp_valid_q, i_resp_valid_d;
  logic                d_resp_valid_q, d_resp_valid_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                open_c;
  logic                grant_i_c, grant_d_c;
  logic [STREAK_W-1:0] streak_nxt_c;

  // run_q keeps both readies low while reset is asserted, without using rst_n as data.
  assign open_c = run_q && (state_q == ARB_IDLE);

  mem_arb_pick #(
    .MAX_STREAK (MAX_STREAK),
    .STREAK_W   (STREAK_W)
  ) u_pick (
    .i_valid      (i_req_valid && open_c),
    .d_valid      (d_req_valid && open_c),
    .streak       (streak_q),
    .grant_i_c    (grant_i_c),
    .grant_d_c    (grant_d_c),
    .streak_nxt_c (streak_nxt_c)
  );

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    streak_d        = streak_q;
    mem_req_valid_d = mem_req_valid_q;
    addr_d          = addr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    i_resp_valid_d  = 1'b0;
    d_resp_valid_d  = 1'b0;
    i_rdata_d       = i_rdata_q;
    d_rdata_d       = d_rdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (grant_d_c) begin
          state_d         = ARB_REQ;
          owner_d         = ARB_OWN_D;
          streak_d        = streak_nxt_c;
          mem_req_valid_d = 1'b1;
          addr_d          = d_req_addr;
          we_d            = d_req_we;
          wdata_d         = d_req_wdata;
          wstrb_d         = d_req_wstrb;
        end else if (grant_i_c) begin
          state_d         = ARB_REQ;
          owner_d         = ARB_OWN_I;
          streak_d        = streak_nxt_c;
          mem_req_valid_d = 1'b1;
          addr_d          = i_req_addr;
          we_d            = 1'b0;
          wdata_d         = '0;
          wstrb_d         = '0;
        end
      end
      ARB_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_resp_valid) begin
          state_d = ARB_IDLE;
          if (owner_q == ARB_OWN_D) begin
            d_resp_valid_d = 1'b1;
            d_rdata_d      = mem_resp_rdata;
          end else begin
            i_resp_valid_d = 1'b1;
            i_rdata_d      = mem_resp_rdata;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ARB_IDLE;
      owner_q         <= ARB_OWN_I;
      streak_q        <= '0;
      run_q           <= 1'b0;
      mem_req_valid_q <= 1'b0;
      addr_q          <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      i_resp_valid_q  <= 1'b0;
      d_resp_valid_q  <= 1'b0;
      i_rdata_q       <= '0;
      d_rdata_q       <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      streak_q        <= streak_d;
      run_q           <= 1'b1;
      mem_req_valid_q <= mem_req_valid_d;
      addr_q          <= addr_d;
      we_q            <= we_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      i_resp_valid_q  <= i_resp_valid_d;
      d_resp_valid_q  <= d_resp_valid_d;
      i_rdata_q       <= i_rdata_d;
      d_rdata_q       <= d_rdata_d;
    end
  end

  assign i_req_ready   = grant_i_c;
  assign d_req_ready   = grant_d_c;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;
  assign i_resp_valid  = i_resp_valid_q;
  assign i_resp_rdata  = i_rdata_q;
  assign d_resp_valid  = d_resp_valid_q;
  assign d_resp_rdata  = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one unified memory port between instruction fetch (I) and load/store (D) for the multi-cycle core. It accepts one request at a time, drives it to memory with a valid/ready handshake, waits for the response, and routes that response back to the owning requester. D has priority. A streak counter keeps I from starving. It sits between the fetch/LSU stages and the unified memory model.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width; strobe width is DATA_W/8
- `MAX_STREAK`, 4, maximum consecutive D grants while I is waiting; must be ≥1
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `i_req_valid` in 1, `i_req_ready` out 1, `i_req_addr` in ADDR_W: fetch request (read only)
- `i_resp_valid` out 1, `i_resp_rdata` out DATA_W: fetch response
- `d_req_valid` in 1, `d_req_ready` out 1: load/store request handshake
- `d_req_addr` in ADDR_W, `d_req_we` in 1, `d_req_wdata` in DATA_W, `d_req_wstrb` in DATA_W/8: load/store request payload
- `d_resp_valid` out 1, `d_resp_rdata` out DATA_W: load/store response
- `mem_req_valid` out 1, `mem_req_ready` in 1: memory request handshake
- `mem_req_addr` out ADDR_W, `mem_req_we` out 1, `mem_req_wdata` out DATA_W, `mem_req_wstrb` out DATA_W/8: memory request payload
- `mem_resp_valid` in 1, `mem_resp_rdata` in DATA_W: memory response

## Operation
- **States:** IDLE, REQ, WAIT.
- **Reset:** state IDLE, owner=none, streak=0.
  - All outputs 0 during reset, including all `*_valid`/`*_ready`, and all payload registers.
- **IDLE:**
  - Winner selection:
    - D wins if `d_req_valid`, unless streak==MAX_STREAK and `i_req_valid`; then I wins.
    - Otherwise I wins if `i_req_valid`.
  - Only the winner's `*_req_ready` is high. Ready is combinational from valid, in IDLE only.
  - On the handshake:
    - Latch the payload into the `mem_req_*` registers. An I request latches we=0, wstrb=0, wdata=0.
    - Record the owner and go to REQ.
- **Streak update, on each grant:**
  - D grant while `i_req_valid`: streak+1, saturating at MAX_STREAK.
  - I grant, or D grant with I idle: streak=0.
- **REQ:** `mem_req_valid`=1 with the latched payload, held stable. When `mem_req_ready`=1, go to WAIT.
- **WAIT:** on `mem_resp_valid`, pulse the owner's `*_resp_valid` for one cycle with rdata, then return to IDLE.
  - A store also returns a response; its rdata is don't-care.
- **Unsolicited responses:** `mem_resp_valid` in IDLE or REQ is ignored; no resp pulse is generated.
- **No combinational loops:**
  - No path from `mem_req_ready` to `*_req_ready`.
  - No path from `mem_resp_valid` to `mem_req_valid`.

## Timing
- At most one transaction outstanding.
- Request accepted in cycle N → `mem_req_valid` high from N+1.
- Memory handshake in cycle M → WAIT from M+1.
- Response in cycle R → `*_resp_valid` in R+1 (registered). Next request acceptable in R+1, since state is IDLE in R+1.
- Best case with memory ready and responding immediately: request at N, `mem_req_valid` N+1, response sampled N+2, resp pulse N+3.
  - Back-to-back acceptance every 3 cycles.
- **Simultaneous events:**
  - I and D valid in the same IDLE cycle: D wins unless the streak is saturated.
  - A new request in the same cycle as the resp pulse is accepted.
- A requester may drop valid before ready; nothing is latched. A valid not granted stays pending, and the requester must hold its payload.
- **Reset mid-operation:** immediate return to IDLE with outputs 0. A late `mem_resp_valid` after deassertion is ignored.

## Structure
- Shared defines file:
  - State encodings ARB_IDLE=2'd0, ARB_REQ=2'd1, ARB_WAIT=2'd2.
  - Owner codes ARB_OWN_I=1'b0, ARB_OWN_D=1'b1.
- One natural sub-module, `mem_arb_pick`: combinational winner/ready/streak-next logic, with inputs valids, streak and MAX_STREAK.
- Parent holds the FSM, the payload registers and the response routing.

## Test plan
- Single fetch: I addr=0x80000000, memory returns 0x00a00093 after 2 cycles → one `i_resp_valid` pulse with rdata=0x00a00093; `d_resp_valid` stays 0; `mem_req_we`=0.
- Contention: I and D valid together, D store addr=0x80001000 wdata=0x1E wstrb=0xFF → D granted first, `mem_req_we`=1; then I granted; responses routed to the correct owners in order.
- Starvation: D valid continuously, I valid continuously, MAX_STREAK=4 → grant sequence D,D,D,D,I,D,D,D,D,I.
- Backpressure: `mem_req_ready` low for 5 cycles → `mem_req_valid` and payload held constant for all 5; no new `*_req_ready` issued.
- Unsolicited response: `mem_resp_valid` pulsed in IDLE → no resp pulse, state stays IDLE.
- Reset in WAIT: `rst_n` low for 1 cycle, then memory responds → all outputs 0 during reset, no resp pulse, next I request served normally.
